// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer code conversions and the Gray full-compare.
// Helpers work on a wide carrier type; callers zero-extend and slice back to pointer width.
package fifo_pkg;

   localparam int ADDRSIZE_DEF = 4;
   localparam int PTR_MAXW     = 32;

   typedef logic [PTR_MAXW-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAXW-1] = g[PTR_MAXW-1];
      for (int i = PTR_MAXW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // A full FIFO's write Gray pointer equals the read one with its top two bits inverted.
   function automatic ptr_t full_cmp(input ptr_t p, input int unsigned w);
      return p ^ (ptr_t'(3) << (w - 2));
   endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer bringing the read-domain Gray pointer into wclk.
module sync_r2w #(
   parameter int W = 5
) (
   input  logic         wclk,
   input  logic         wrst_n,
   input  logic [W-1:0] rptr,
   output logic [W-1:0] wq2_rptr
);

   logic [W-1:0] wq1_rptr;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wq1_rptr <= '0;
         wq2_rptr <= '0;
      end else begin
         wq1_rptr <= rptr;
         wq2_rptr <= wq1_rptr;
      end
   end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer owner for the async FIFO: binary/Gray write counter, full,
// almost-full, conservative fill level and sticky overflow, all in the wclk domain.
module wptr_full_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE     = ADDRSIZE_DEF,
   parameter int AFULL_THRESH = 12
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                winc,
   input  logic                wovf_clr,
   input  logic [ADDRSIZE:0]   rptr,
   output logic [ADDRSIZE:0]   wptr,
   output logic [ADDRSIZE-1:0] waddr,
   output logic                wclken,
   output logic                wfull,
   output logic                walmost_full,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                woverflow
);

   localparam int PW = ADDRSIZE + 1;
   localparam logic [ADDRSIZE:0] AFULL_LVL = PW'(AFULL_THRESH);

   logic [ADDRSIZE:0] wbin;
   logic [ADDRSIZE:0] wbinnext;
   logic [ADDRSIZE:0] wgraynext;
   logic [ADDRSIZE:0] wq2_rptr;
   logic [ADDRSIZE:0] wq2_rbin;
   logic [ADDRSIZE:0] full_ref;
   logic [ADDRSIZE:0] level_next;
   ptr_t              gray_ext;
   ptr_t              rbin_ext;
   ptr_t              fref_ext;
   logic              unused_hi;

   sync_r2w #(.W(PW)) u_sync_r2w (
      .wclk     (wclk),
      .wrst_n   (wrst_n),
      .rptr     (rptr),
      .wq2_rptr (wq2_rptr)
   );

   // A write is only accepted when not full; dropped writes leave the pointers alone.
   assign wclken    = winc & ~wfull;
   assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wclken};
   assign waddr     = wbin[ADDRSIZE-1:0];

   assign gray_ext  = bin2gray(ptr_t'(wbinnext));
   assign rbin_ext  = gray2bin(ptr_t'(wq2_rptr));
   assign fref_ext  = full_cmp(ptr_t'(wq2_rptr), PW);
   assign wgraynext = gray_ext[ADDRSIZE:0];
   assign wq2_rbin  = rbin_ext[ADDRSIZE:0];
   assign full_ref  = fref_ext[ADDRSIZE:0];
   assign unused_hi = ^{gray_ext[PTR_MAXW-1:PW], rbin_ext[PTR_MAXW-1:PW], fref_ext[PTR_MAXW-1:PW]};

   // Level uses the stale synchronized read pointer, so it can only over-report.
   assign level_next = wbinnext - wq2_rbin;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin         <= '0;
         wptr         <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         woverflow    <= 1'b0;
      end else begin
         wbin         <= wbinnext;
         wptr         <= wgraynext;
         wfull        <= (wgraynext == full_ref);
         walmost_full <= (level_next >= AFULL_LVL);
         wlevel       <= level_next;
         if (winc && wfull) begin
            woverflow <= 1'b1;
         end else if (wovf_clr) begin
            woverflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: count-based reference model feeding an expected queue.
module tb_wptr_full_ctrl;

   localparam int A = 4;
   localparam int W = 18;

   logic         wclk = 1'b0;
   logic         wrst_n = 1'b0;
   logic         winc = 1'b0;
   logic         wovf_clr = 1'b0;
   logic [A:0]   rptr = '0;
   logic [A:0]   wptr;
   logic [A-1:0] waddr;
   logic         wclken;
   logic         wfull;
   logic         walmost_full;
   logic [A:0]   wlevel;
   logic         woverflow;

   wptr_full_ctrl #(.ADDRSIZE(A), .AFULL_THRESH(12)) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .winc         (winc),
      .wovf_clr     (wovf_clr),
      .rptr         (rptr),
      .wptr         (wptr),
      .waddr        (waddr),
      .wclken       (wclken),
      .wfull        (wfull),
      .walmost_full (walmost_full),
      .wlevel       (wlevel),
      .woverflow    (woverflow)
   );

   always #5 wclk = ~wclk;

   int checks = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_vec;
   logic [W-1:0] got_vec;

   // Reference model in plain write/read counts (not wrapped pointers).
   int m_wr, m_q1, m_q2;
   bit m_full, m_ovf;

   function automatic logic [A:0] gray(input int n);
      logic [A:0] b;
      b = n[A:0];
      return b ^ (b >> 1);
   endfunction

   task automatic model_reset();
      m_wr = 0; m_q1 = 0; m_q2 = 0; m_full = 0; m_ovf = 0;
      exp_q.delete();
   endtask

   // Vector layout: {wclken(pre-edge), wptr, waddr, wfull, walmost_full, wlevel, woverflow}
   task automatic drive_cycle(input bit inc, input bit clr, input int rd);
      int   nxt, lvl, ad;
      bit   e_ovf, e_ce;
      logic ce_pre;
      @(negedge wclk);
      winc = inc; wovf_clr = clr; rptr = gray(rd);
      e_ce  = inc && !m_full;
      nxt   = m_wr + int'(e_ce);
      lvl   = nxt - m_q2;
      ad    = nxt % 16;
      e_ovf = (inc && m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
      exp_q.push_back({e_ce, gray(nxt), ad[3:0], lvl == 16, lvl >= 12, lvl[4:0], e_ovf});
      m_wr = nxt; m_full = (lvl == 16); m_ovf = e_ovf; m_q2 = m_q1; m_q1 = rd;
      #1 ce_pre = wclken;
      @(posedge wclk);
      #1;
      got_vec = {ce_pre, wptr, waddr, wfull, walmost_full, wlevel, woverflow};
      exp_vec = exp_q.pop_front();
      winc = 1'b0; wovf_clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge wclk);
      wrst_n = 1'b0; winc = 1'b0; wovf_clr = 1'b0; rptr = '0;
      @(negedge wclk);
      wrst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge wclk);
         winc = 1'($urandom_range(0, 1)); rptr = 5'($urandom_range(0, 31));
      end
      @(posedge wclk);
      #2 wrst_n = 1'b0;
      #1;
      checks++;
      if ({wptr, waddr, wfull, walmost_full, wlevel, woverflow} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got wptr=%b waddr=%0d full=%b afull=%b level=%0d ovf=%b required all zero",
                  wptr, waddr, wfull, walmost_full, wlevel, woverflow);
      end
      @(negedge wclk);
      winc = 1'b0; rptr = '0;
      @(negedge wclk);
      wrst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         drive_cycle(1'b1, 1'b0, 0);
         checks++;
         if (got_vec !== exp_vec) begin
            failures++;
            $display("FAIL fill[%0d] got=%h required=%h", i, got_vec, exp_vec);
         end
         if (i == 10 || i == 11) begin
            checks++;
            if (walmost_full !== (i == 11)) begin
               failures++;
               $display("FAIL afull_edge[%0d] got=%b required=%b", i, walmost_full, i == 11);
            end
         end
      end
      checks++;
      if (wptr !== 5'b11000 || wfull !== 1'b1 || wlevel !== 5'd16) begin
         failures++;
         $display("FAIL fill_end got wptr=%b full=%b level=%0d required 11000/1/16", wptr, wfull, wlevel);
      end
   endtask

   task automatic test_overflow();
      drive_cycle(1'b1, 1'b0, 0);
      checks++;
      if (got_vec !== exp_vec || woverflow !== 1'b1 || wptr !== 5'b11000 || waddr !== 4'd0) begin
         failures++;
         $display("FAIL ovf_set got=%h required=%h", got_vec, exp_vec);
      end
      drive_cycle(1'b1, 1'b1, 0);
      checks++;
      if (got_vec !== exp_vec || woverflow !== 1'b1) begin
         failures++;
         $display("FAIL ovf_set_wins got=%h required=%h", got_vec, exp_vec);
      end
      drive_cycle(1'b0, 1'b1, 0);
      checks++;
      if (got_vec !== exp_vec || woverflow !== 1'b0) begin
         failures++;
         $display("FAIL ovf_clr got=%h required=%h", got_vec, exp_vec);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 1'b0, 1);
         checks++;
         if (got_vec !== exp_vec || wfull !== (i < 2)) begin
            failures++;
            $display("FAIL drain[%0d] got=%h full=%b required=%h full=%b", i, got_vec, wfull, exp_vec, i < 2);
         end
      end
      checks++;
      if (wlevel !== 5'd15) begin
         failures++;
         $display("FAIL drain_level got=%0d required=15", wlevel);
      end
   endtask

   task automatic test_wrap();
      bit seen_wrap = 0;
      for (int i = 0; i < 40; i++) begin
         drive_cycle(1'b1, 1'b0, m_wr + 1);
         if (m_wr == 32) seen_wrap = (wptr == 5'b00000);
         checks++;
         if (got_vec !== exp_vec || wfull !== 1'b0 || (i >= 1 && wlevel !== 5'd2)) begin
            failures++;
            $display("FAIL wrap[%0d] got=%h required=%h level=%0d", i, got_vec, exp_vec, wlevel);
         end
      end
      checks++;
      if (!seen_wrap) begin
         failures++;
         $display("FAIL wrap_ptr got no wptr=00000 at 32 writes required wrap");
      end
   endtask

   task automatic test_reset_midfill();
      for (int i = 0; i < 10; i++) begin
         drive_cycle(1'b1, 1'b0, 0);
         checks++;
         if (got_vec !== exp_vec) begin
            failures++;
            $display("FAIL midfill[%0d] got=%h required=%h", i, got_vec, exp_vec);
         end
      end
      @(negedge wclk);
      wrst_n = 1'b0;
      #1;
      checks++;
      if (wlevel !== '0 || wptr !== '0 || waddr !== '0) begin
         failures++;
         $display("FAIL midfill_reset got level=%0d wptr=%b waddr=%0d required 0", wlevel, wptr, waddr);
      end
      @(negedge wclk);
      wrst_n = 1'b1;
      model_reset();
      drive_cycle(1'b1, 1'b0, 0);
      checks++;
      if (got_vec !== exp_vec || waddr !== 4'd1) begin
         failures++;
         $display("FAIL after_reset_write got=%h required=%h", got_vec, exp_vec);
      end
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge wclk);
      wrst_n = 1'b1;
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      do_reset();
      test_wrap();
      do_reset();
      test_reset_midfill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
